// File: rtl/behav_gate_pkg.sv
// Shared definitions for the registered gate unit: gate encoding, gate count
// and the single-bit gate evaluator used by every bit slice.
package behav_gate_pkg;

    typedef enum logic [2:0] {
        GATE_AND  = 3'd0,
        GATE_OR   = 3'd1,
        GATE_NOT  = 3'd2,
        GATE_NAND = 3'd3,
        GATE_NOR  = 3'd4,
        GATE_XOR  = 3'd5,
        GATE_XNOR = 3'd6
    } gate_op_e;

    localparam int NUM_GATES = 7;

    // NOT ignores b_bit; every other gate is a plain two-input function.
    function automatic logic gate_eval(input gate_op_e op, input logic a_bit, input logic b_bit);
        case (op)
            GATE_AND:  return a_bit & b_bit;
            GATE_OR:   return a_bit | b_bit;
            GATE_NOT:  return ~a_bit;
            GATE_NAND: return ~(a_bit & b_bit);
            GATE_NOR:  return ~(a_bit | b_bit);
            GATE_XOR:  return a_bit ^ b_bit;
            GATE_XNOR: return ~(a_bit ^ b_bit);
            default:   return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/behav_gate_bit.sv
// One bit slice of the gate unit: all seven combinational gate results for a
// single operand bit pair, indexed by gate_op_e.
module behav_gate_bit
    import behav_gate_pkg::*;
(
    input  logic                 i_a,
    input  logic                 i_b,
    output logic [NUM_GATES-1:0] o_res
);

    always_comb begin
        o_res            = '0;
        o_res[GATE_AND]  = gate_eval(GATE_AND,  i_a, i_b);
        o_res[GATE_OR]   = gate_eval(GATE_OR,   i_a, i_b);
        o_res[GATE_NOT]  = gate_eval(GATE_NOT,  i_a, i_b);
        o_res[GATE_NAND] = gate_eval(GATE_NAND, i_a, i_b);
        o_res[GATE_NOR]  = gate_eval(GATE_NOR,  i_a, i_b);
        o_res[GATE_XOR]  = gate_eval(GATE_XOR,  i_a, i_b);
        o_res[GATE_XNOR] = gate_eval(GATE_XNOR, i_a, i_b);
    end

endmodule

// File: rtl/behav_gate_unit.sv
// Registered bitwise gate unit: seven gate results of a/b, one-cycle latency.
// Optional macro BEHAV_GATE_PARITY_EN adds a registered 7-bit parity output par_o.
module behav_gate_unit
    import behav_gate_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    output logic [WIDTH-1:0] and_g,
    output logic [WIDTH-1:0] or_g,
    output logic [WIDTH-1:0] not_g,
    output logic [WIDTH-1:0] nand_g,
    output logic [WIDTH-1:0] nor_g,
    output logic [WIDTH-1:0] xor_g,
    output logic [WIDTH-1:0] xnor_g
`ifdef BEHAV_GATE_PARITY_EN
    ,
    output logic [NUM_GATES-1:0] par_o
`endif
);

    logic [NUM_GATES-1:0] w_bitRes [WIDTH];
    logic [WIDTH-1:0]     w_gate   [NUM_GATES];
    logic [WIDTH-1:0]     r_gate   [NUM_GATES];
    logic                 r_valid;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        behav_gate_bit u_bit (
            .i_a   (a[i]),
            .i_b   (b[i]),
            .o_res (w_bitRes[i])
        );
    end

    // Regroup per-bit slices into one WIDTH-wide vector per gate.
    always_comb begin
        for (int k = 0; k < NUM_GATES; k++) begin
            w_gate[k] = '0;
            for (int i = 0; i < WIDTH; i++) begin
                w_gate[k][i] = w_bitRes[i][k];
            end
        end
    end

    // Results load only on a valid sample, so X on idle operands never enters the flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            for (int k = 0; k < NUM_GATES; k++) begin
                r_gate[k] <= '0;
            end
        end else begin
            r_valid <= in_valid;
            if (in_valid) begin
                for (int k = 0; k < NUM_GATES; k++) begin
                    r_gate[k] <= w_gate[k];
                end
            end
        end
    end

    assign out_valid = r_valid;
    assign and_g     = r_gate[int'(GATE_AND)];
    assign or_g      = r_gate[int'(GATE_OR)];
    assign not_g     = r_gate[int'(GATE_NOT)];
    assign nand_g    = r_gate[int'(GATE_NAND)];
    assign nor_g     = r_gate[int'(GATE_NOR)];
    assign xor_g     = r_gate[int'(GATE_XOR)];
    assign xnor_g    = r_gate[int'(GATE_XNOR)];

`ifdef BEHAV_GATE_PARITY_EN
    logic [NUM_GATES-1:0] w_par;
    logic [NUM_GATES-1:0] r_par;

    always_comb begin
        w_par = '0;
        for (int k = 0; k < NUM_GATES; k++) begin
            w_par[k] = ^w_gate[k];
        end
    end

    // Parity follows exactly the same load/hold/reset rules as the results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_par <= '0;
        end else if (in_valid) begin
            r_par <= w_par;
        end
    end

    assign par_o = r_par;
`endif

endmodule

// File: tb/tb_behav_gate_unit.sv
// Scoreboard bench for behav_gate_unit: a WIDTH=1 instance for the truth table
// and a WIDTH=8 instance for vectors, hold, reset, throughput and parity.
module tb_behav_gate_unit;

    logic clk = 1'b0;
    logic rst_n = 1'b1;

    logic       in_valid1 = 1'b0;
    logic [0:0] a1 = '0, b1 = '0;
    logic       ov1;
    logic [0:0] and1, or1, not1, nand1, nor1, xor1, xnor1;

    logic       in_valid8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       ov8;
    logic [7:0] and8, or8, not8, nand8, nor8, xor8, xnor8;
`ifdef BEHAV_GATE_PARITY_EN
    logic [6:0] par8;
`endif

    int total = 0;
    int bad   = 0;

    logic [55:0] sb8 [$];
    logic [6:0]  sb1 [$];

    always #5 clk = ~clk;

    behav_gate_unit #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .a(a1), .b(b1),
        .out_valid(ov1), .and_g(and1), .or_g(or1), .not_g(not1), .nand_g(nand1),
        .nor_g(nor1), .xor_g(xor1), .xnor_g(xnor1)
`ifdef BEHAV_GATE_PARITY_EN
        , .par_o()
`endif
    );

    behav_gate_unit #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .a(a8), .b(b8),
        .out_valid(ov8), .and_g(and8), .or_g(or8), .not_g(not8), .nand_g(nand8),
        .nor_g(nor8), .xor_g(xor8), .xnor_g(xnor8)
`ifdef BEHAV_GATE_PARITY_EN
        , .par_o(par8)
`endif
    );

    wire [55:0] act8 = {and8, or8, not8, nand8, nor8, xor8, xnor8};
    wire [6:0]  act1 = {and1, or1, not1, nand1, nor1, xor1, xnor1};

    // Reference model, packed as {and, or, not, nand, nor, xor, xnor}.
    function automatic logic [55:0] model8(input logic [7:0] a, input logic [7:0] b);
        return {a & b, a | b, ~a, ~(a & b), ~(a | b), a ^ b, ~(a ^ b)};
    endfunction

    function automatic logic [6:0] model1(input logic a, input logic b);
        return {a & b, a | b, ~a, ~(a & b), ~(a | b), a ^ b, ~(a ^ b)};
    endfunction

    // par[k] with k=0 for AND (top byte of the packed model) up to k=6 for XNOR.
    function automatic logic [6:0] parModel(input logic [55:0] r);
        logic [6:0] p;
        for (int k = 0; k < 7; k++) p[k] = ^r[55-8*k -: 8];
        return p;
    endfunction

    task automatic drive8(input logic v, input logic [7:0] a, input logic [7:0] b);
        in_valid8 = v;
        a8 = a;
        b8 = b;
        if (v) sb8.push_back(model8(a, b));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        total++;
        if ({ov8, act8} !== 57'd0) begin
            bad++;
            $display("[TB] FAIL reset_w8 got=%h want=%h", {ov8, act8}, 57'd0);
        end
        total++;
        if ({ov1, act1} !== 8'd0) begin
            bad++;
            $display("[TB] FAIL reset_w1 got=%h want=%h", {ov1, act1}, 8'd0);
        end
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_truth_table();
        logic [6:0] exp;
        for (int i = 0; i < 4; i++) begin
            in_valid1 = 1'b1;
            a1 = 1'(i >> 1);
            b1 = 1'(i);
            sb1.push_back(model1(a1[0], b1[0]));
            tick();
            total++;
            if (sb1.size() == 0) begin
                bad++;
                $display("[TB] FAIL truth_empty_sb got=0 want=1");
            end else begin
                exp = sb1.pop_front();
                if ({ov1, act1} !== {1'b1, exp}) begin
                    bad++;
                    $display("[TB] FAIL truth_ab%0d got=%b want=%b", i, {ov1, act1}, {1'b1, exp});
                end
            end
        end
        in_valid1 = 1'b0;
    endtask

    task automatic test_wide();
        logic [55:0] exp;
        drive8(1'b1, 8'hF0, 8'hCC);
        tick();
        exp = sb8.pop_front();
        total++;
        if ({ov8, act8} !== {1'b1, exp} || exp !== 56'hC0_FC_0F_3F_03_3C_C3) begin
            bad++;
            $display("[TB] FAIL wide_f0_cc got=%h want=%h", {ov8, act8}, {1'b1, 56'hC0_FC_0F_3F_03_3C_C3});
        end
    endtask

    task automatic test_hold();
        logic [55:0] exp;
        drive8(1'b1, 8'h01, 8'h00);
        tick();
        exp = sb8.pop_front();
        total++;
        if ({ov8, act8} !== {1'b1, exp}) begin
            bad++;
            $display("[TB] FAIL hold_load got=%h want=%h", {ov8, act8}, {1'b1, exp});
        end
        drive8(1'b0, 8'h01, 8'h01);
        tick();
        total++;
        if ({ov8, act8} !== {1'b0, exp}) begin
            bad++;
            $display("[TB] FAIL hold_idle got=%h want=%h", {ov8, act8}, {1'b0, exp});
        end
        in_valid8 = 1'b0;
        a8 = 'x;
        b8 = 'x;
        tick();
        total++;
        if ({ov8, act8} !== {1'b0, exp}) begin
            bad++;
            $display("[TB] FAIL hold_x_idle got=%h want=%h", {ov8, act8}, {1'b0, exp});
        end
    endtask

    task automatic test_async_reset();
        drive8(1'b1, 8'hAA, 8'h0F);
        tick();
        void'(sb8.pop_front());
        drive8(1'b1, 8'h5A, 8'h33);
        sb8.delete();
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if ({ov8, act8} !== 57'd0) begin
            bad++;
            $display("[TB] FAIL async_reset got=%h want=%h", {ov8, act8}, 57'd0);
        end
        drive8(1'b0, 8'h00, 8'h00);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            total++;
            if ({ov8, act8} !== 57'd0) begin
                bad++;
                $display("[TB] FAIL post_reset_idle%0d got=%h want=%h", i, {ov8, act8}, 57'd0);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [55:0] exp;
        for (int i = 0; i < 16; i++) begin
            drive8(1'b1, 8'($urandom), 8'($urandom));
            tick();
            total++;
            if (sb8.size() == 0) begin
                bad++;
                $display("[TB] FAIL b2b_empty_sb%0d got=0 want=1", i);
            end else begin
                exp = sb8.pop_front();
                if ({ov8, act8} !== {1'b1, exp}) begin
                    bad++;
                    $display("[TB] FAIL b2b%0d got=%h want=%h", i, {ov8, act8}, {1'b1, exp});
                end
            end
            total++;
            if ({nand8, nor8, xnor8} !== {~and8, ~or8, ~xor8}) begin
                bad++;
                $display("[TB] FAIL b2b_invariant%0d got=%h want=%h", i, {nand8, nor8, xnor8}, {~and8, ~or8, ~xor8});
            end
        end
        drive8(1'b0, 8'h00, 8'h00);
        tick();
        total++;
        if (sb8.size() != 0 || ov8 !== 1'b0) begin
            bad++;
            $display("[TB] FAIL b2b_drain got=%0d/%b want=0/0", sb8.size(), ov8);
        end
    endtask

`ifdef BEHAV_GATE_PARITY_EN
    task automatic test_parity();
        logic [55:0] exp;
        drive8(1'b1, 8'hF0, 8'hCC);
        tick();
        exp = sb8.pop_front();
        total++;
        if (par8 !== 7'b0000000 || parModel(exp) !== 7'b0000000) begin
            bad++;
            $display("[TB] FAIL parity_even got=%b want=%b", par8, 7'b0000000);
        end
        drive8(1'b1, 8'h01, 8'h00);
        tick();
        exp = sb8.pop_front();
        total++;
        if (par8 !== parModel(exp)) begin
            bad++;
            $display("[TB] FAIL parity_01_00 got=%b want=%b", par8, parModel(exp));
        end
        drive8(1'b0, 8'hFF, 8'h00);
        tick();
        total++;
        if (par8 !== parModel(exp)) begin
            bad++;
            $display("[TB] FAIL parity_hold got=%b want=%b", par8, parModel(exp));
        end
    endtask
`endif

    initial begin
        test_reset();
        test_truth_table();
        test_wide();
        test_hold();
        test_async_reset();
        test_back_to_back();
`ifdef BEHAV_GATE_PARITY_EN
        test_parity();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
